apb_uart_tx_bridge: RTL

// - APB slave data stage for the UART transmit register. Sits directly after the 4-bit address decoder.
// - Consumes the decoder's 'transfer' flag plus the APB phase signals.
// - Accepts PWDATA bytes into a small TX FIFO and returns FIFO status on reads.
// - Feeds the UART transmitter through a valid/ready byte stream.

---
 rtl/uart_apb_pkg.sv | 17 +
 rtl/uart_tx_fifo.sv | 52 +++++
 rtl/apb_uart_tx_bridge.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/uart_apb_pkg.sv
// Shared types and constants for the APB-to-UART-TX bridge: FSM states,
// status-word bit positions and the default data width.
package uart_apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2
  } apb_state_e;

  localparam int ST_EMPTY     = 0;
  localparam int ST_FULL      = 1;
  localparam int ST_COUNT_LSB = 2;

  localparam int DEF_DATA_W = 8;

endpackage

// File: rtl/uart_tx_fifo.sv
// Small synchronous TX FIFO. Push is refused when full, pop is ignored when
// empty; simultaneous push and pop keeps the count and advances both pointers.
module uart_tx_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic              full,
  output logic              empty,
  output logic [CNT_W-1:0]  count
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              w_push_ok;
  logic              w_pop_ok;

  assign full      = (r_count == CNT_W'(DEPTH));
  assign empty     = (r_count == '0);
  assign count     = r_count;
  assign head      = r_mem[r_rd_ptr];
  assign w_push_ok = push && !full;
  assign w_pop_ok  = pop && !empty;

  // Pointers are exactly log2(DEPTH) wide, so they wrap without compare logic.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_push_ok) begin
        r_mem[r_wr_ptr] <= push_data;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop_ok) r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push_ok && !w_pop_ok)      r_count <= r_count + 1'b1;
      else if (w_pop_ok && !w_push_ok) r_count <= r_count - 1'b1;
    end
  end

endmodule

// File: rtl/apb_uart_tx_bridge.sv
// APB data stage for the UART TX register: writes push into the TX FIFO,
// reads return {count, full, empty}. Optional wait-state timeout: APB_TIMEOUT_EN.
module apb_uart_tx_bridge
  import uart_apb_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int DEPTH       = 4,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              transfer,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [DATA_W-1:0] PWDATA,
  output logic              PREADY,
  output logic [DATA_W-1:0] PRDATA,
  output logic              PSLVERR,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic [1:0]        o_dbg_state
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  apb_state_e        r_state;
  apb_state_e        w_next;
  logic [DATA_W-1:0] r_prdata;
  logic [DATA_W-1:0] w_status;
  logic              w_push;
  logic              w_pready;
  logic              w_pslverr;
  logic              w_full;
  logic              w_empty;
  logic [CNT_W-1:0]  w_count;

  // A zero timeout would make every full-FIFO write fail immediately.
  if (TIMEOUT_CYC < 1) begin : g_bad_timeout_cfg
    localparam int TIMEOUT_INVALID = 1;
  end

  uart_tx_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .PCLK      (PCLK),
    .PRESET    (PRESET),
    .push      (w_push),
    .push_data (PWDATA),
    .pop       (tx_ready && tx_valid),
    .head      (tx_data),
    .full      (w_full),
    .empty     (w_empty),
    .count     (w_count)
  );

  assign tx_valid    = !w_empty;
  assign PREADY      = w_pready;
  assign PSLVERR     = w_pslverr;
  assign PRDATA      = r_prdata;
  assign o_dbg_state = r_state;

  always_comb begin
    w_status                           = '0;
    w_status[ST_EMPTY]                 = w_empty;
    w_status[ST_FULL]                  = w_full;
    w_status[ST_COUNT_LSB +: CNT_W]    = w_count;
  end

`ifdef APB_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TO_W-1:0] r_to_cnt;
  logic            w_timeout;

  assign w_timeout = (r_to_cnt == TO_W'(TIMEOUT_CYC));

  // Counts only while we stay in WAIT; entry and exit both clear it.
  always_ff @(posedge PCLK) begin
    if (PRESET || r_state != WAIT || w_next != WAIT) r_to_cnt <= '0;
    else                                             r_to_cnt <= r_to_cnt + 1'b1;
  end
`else
  logic w_timeout;
  assign w_timeout = 1'b0;
`endif

  // Valid/ready on APB: a transfer completes in the cycle PREADY is high;
  // transfer dropping in ACCESS/WAIT abandons the access without a push.
  always_comb begin
    w_next    = r_state;
    w_pready  = 1'b0;
    w_pslverr = 1'b0;
    w_push    = 1'b0;
    case (r_state)
      IDLE: begin
        if (transfer && !PENABLE) w_next = ACCESS;
      end
      ACCESS: begin
        if (!transfer) begin
          w_next = IDLE;
        end else if (!PWRITE) begin
          w_pready = 1'b1;
          w_next   = IDLE;
        end else if (!w_full) begin
          w_push   = 1'b1;
          w_pready = 1'b1;
          w_next   = IDLE;
        end else begin
          w_next = WAIT;
        end
      end
      WAIT: begin
        if (!transfer) begin
          w_next = IDLE;
        end else if (!w_full) begin
          w_push   = 1'b1;
          w_pready = 1'b1;
          w_next   = IDLE;
        end else if (w_timeout) begin
          w_pready  = 1'b1;
          w_pslverr = 1'b1;
          w_next    = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Status is sampled on the setup edge and held until the next read.
  always_ff @(posedge PCLK) begin
    if (PRESET)                                                      r_prdata <= '0;
    else if (r_state == IDLE && transfer && !PENABLE && !PWRITE)     r_prdata <= w_status;
  end

endmodule
